mytdm_demux2: RTL and testbench

MYTDM_DEMUX2 -- requirements
Module: mytdm_demux2

---
 rtl/mytdm_demux2.sv | 143 ++++++++++++++
 tb/tb_mytdm_demux2.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mytdm_demux2.sv
`default_nettype none
// ============================================================================
// Module      : mytdm_demux2
// Description : 2-channel TDM serial demultiplexer with frame sync, abort
//               detection and optional even-parity check (macro PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module mytdm_demux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic             valid,
  output logic             err
);

  localparam int              c_CW   = $clog2(2*WIDTH+1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(2*WIDTH-1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sh0;
  logic [WIDTH-1:0] r_sh1;
  logic [WIDTH-1:0] w_y1;
  logic             w_start;
  logic             w_shift;
  logic             w_load;
  logic             w_abort;
  logic             w_perr;
`ifdef PARITY_EN
  logic             r_par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_load  = 1'b0;
    w_abort = 1'b0;
    w_perr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (sync) begin
          w_start = 1'b1;
          w_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (sync) begin
          // Sync mid-frame restarts on this bit and flags the lost frame.
          w_start = 1'b1;
          w_abort = 1'b1;
        end else begin
          w_shift = 1'b1;
          if (r_cnt == c_LAST) begin
`ifdef PARITY_EN
            w_next = PARITY;
`else
            w_load = 1'b1;
            w_next = IDLE;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (sync) begin
          w_start = 1'b1;
          w_abort = 1'b1;
        end else begin
          w_next = IDLE;
          if (din == r_par) w_load = 1'b1;
          else              w_perr = 1'b1;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // The final channel-1 bit is still on din when the words load without parity.
`ifdef PARITY_EN
  assign w_y1 = r_sh1;
`else
  assign w_y1 = {r_sh1[WIDTH-2:0], din};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh0 <= '0;
      r_sh1 <= '0;
      Y0    <= '0;
      Y1    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
`ifdef PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      valid <= w_load;
      err   <= w_abort | w_perr;
      if (w_start) begin
        r_sh0 <= {r_sh0[WIDTH-2:0], din};
        r_cnt <= c_ONE;
`ifdef PARITY_EN
        r_par <= din;
`endif
      end else if (w_shift) begin
        if (r_cnt[0]) r_sh1 <= {r_sh1[WIDTH-2:0], din};
        else          r_sh0 <= {r_sh0[WIDTH-2:0], din};
        r_cnt <= r_cnt + c_ONE;
`ifdef PARITY_EN
        r_par <= r_par ^ din;
`endif
      end
      if (w_next == IDLE) r_cnt <= '0;
      if (w_load) begin
        Y0 <= r_sh0;
        Y1 <= w_y1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mytdm_demux2.sv
`default_nettype none
// ============================================================================
// Module      : tb_mytdm_demux2
// Description : Self-checking bench for mytdm_demux2 (honours PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mytdm_demux2;

  localparam int WIDTH = 8;
  localparam int DL    = 2*WIDTH;
`ifdef PARITY_EN
  localparam int FL    = DL + 1;
`else
  localparam int FL    = DL;
`endif

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             din   = 1'b0;
  logic             sync  = 1'b0;
  logic [WIDTH-1:0] Y0;
  logic [WIDTH-1:0] Y1;
  logic             valid;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Frame-level reference stream: per-cycle stimulus and expected outputs.
  logic             q_d[$];
  logic             q_s[$];
  logic             q_v[$];
  logic             q_e[$];
  logic [WIDTH-1:0] q_y0[$];
  logic [WIDTH-1:0] q_y1[$];
  logic [WIDTH-1:0] m_y0;
  logic [WIDTH-1:0] m_y1;
  logic             m_pend;

  mytdm_demux2 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .sync  (sync),
    .Y0    (Y0),
    .Y1    (Y1),
    .valid (valid),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic fbit(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k);
    if (k >= DL) return ^{a, b};
    if (k % 2 == 0) return a[WIDTH-1-k/2];
    return b[WIDTH-1-k/2];
  endfunction

  task automatic step(input logic d, input logic s);
    din  = d;
    sync = s;
    @(posedge clk);
    #1;
  endtask

  // Sends frame bits k0..k1-1; counts valid/err seen before the final bit.
  task automatic send_bits(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic flip,
                           input int k0, input int k1, output int nv, output int ne);
    nv = 0;
    ne = 0;
    for (int k = k0; k < k1; k++) begin
      step(fbit(a, b, k) ^ (flip && k == DL), k == 0);
      if (k < k1 - 1) begin
        nv += int'(valid);
        ne += int'(err);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Y0, Y1, valid, err} !== '0) begin
      errors++;
      $display("FAIL reset_async Y0=%h Y1=%h valid=%b err=%b need all 0", Y0, Y1, valid, err);
    end
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    checks++;
    if ({Y0, Y1, valid, err} !== '0) begin
      errors++;
      $display("FAIL reset_hold Y0=%h Y1=%h valid=%b err=%b need all 0", Y0, Y1, valid, err);
    end
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if ({Y0, Y1, valid, err} !== '0) begin
      errors++;
      $display("FAIL reset_release Y0=%h Y1=%h valid=%b err=%b need all 0", Y0, Y1, valid, err);
    end
  endtask

  task automatic test_basic();
    int nv, ne;
    send_bits(8'hA5, 8'h3C, 1'b0, 0, FL, nv, ne);
    checks++;
    if (nv !== 0 || ne !== 0) begin
      errors++;
      $display("FAIL basic_inframe valid_cnt=%0d err_cnt=%0d need 0/0", nv, ne);
    end
    checks++;
    if (valid !== 1'b1 || err !== 1'b0 || Y0 !== 8'hA5 || Y1 !== 8'h3C) begin
      errors++;
      $display("FAIL basic_out valid=%b err=%b Y0=%h Y1=%h need 1/0/a5/3c", valid, err, Y0, Y1);
    end
    step(1'b0, 1'b0);
    checks++;
    if (valid !== 1'b0 || Y0 !== 8'hA5 || Y1 !== 8'h3C) begin
      errors++;
      $display("FAIL basic_pulse valid=%b Y0=%h Y1=%h need 0/a5/3c", valid, Y0, Y1);
    end
  endtask

  task automatic test_back_to_back();
    int nv, ne, first, vcount, ecount;
    send_bits(8'hA5, 8'h3C, 1'b0, 0, FL, nv, ne);
    checks++;
    if (valid !== 1'b1 || nv !== 0 || ne !== 0) begin
      errors++;
      $display("FAIL b2b_first valid=%b vcnt=%0d ecnt=%0d need 1/0/0", valid, nv, ne);
    end
    first  = -1;
    vcount = 0;
    ecount = 0;
    for (int i = 0; i < FL + 2; i++) begin
      if (i < FL) step(fbit(8'hFF, 8'h00, i), i == 0);
      else        step(1'b0, 1'b0);
      vcount += int'(valid);
      ecount += int'(err);
      if (valid === 1'b1 && first < 0) first = i + 1;
    end
    checks++;
    if (first !== FL || vcount !== 1 || ecount !== 0) begin
      errors++;
      $display("FAIL b2b_spacing gap=%0d vcnt=%0d ecnt=%0d need %0d/1/0", first, vcount, ecount, FL);
    end
    checks++;
    if (Y0 !== 8'hFF || Y1 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_data Y0=%h Y1=%h need ff/00", Y0, Y1);
    end
  endtask

  task automatic test_abort();
    int nv, ne, held_bad;
    send_bits(8'hA5, 8'h3C, 1'b0, 0, 7, nv, ne);
    step(fbit(8'h12, 8'h34, 0), 1'b1);
    checks++;
    if (err !== 1'b1 || valid !== 1'b0 || Y0 !== 8'hFF || Y1 !== 8'h00) begin
      errors++;
      $display("FAIL abort_err err=%b valid=%b Y0=%h Y1=%h need 1/0/ff/00", err, valid, Y0, Y1);
    end
    nv = 0;
    ne = 0;
    held_bad = 0;
    for (int k = 1; k < FL - 1; k++) begin
      step(fbit(8'h12, 8'h34, k), 1'b0);
      nv += int'(valid);
      ne += int'(err);
      if (Y0 !== 8'hFF || Y1 !== 8'h00) held_bad++;
    end
    checks++;
    if (nv !== 0 || ne !== 0 || held_bad !== 0) begin
      errors++;
      $display("FAIL abort_hold vcnt=%0d ecnt=%0d bad_hold=%0d need 0/0/0", nv, ne, held_bad);
    end
    step(fbit(8'h12, 8'h34, FL - 1), 1'b0);
    checks++;
    if (valid !== 1'b1 || err !== 1'b0 || Y0 !== 8'h12 || Y1 !== 8'h34) begin
      errors++;
      $display("FAIL abort_new valid=%b err=%b Y0=%h Y1=%h need 1/0/12/34", valid, err, Y0, Y1);
    end
  endtask

  task automatic test_reset_midframe();
    int nv, ne, ybad;
    send_bits(8'hA5, 8'h3C, 1'b0, 0, 10, nv, ne);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Y0, Y1, valid, err} !== '0) begin
      errors++;
      $display("FAIL midreset_async Y0=%h Y1=%h valid=%b err=%b need all 0", Y0, Y1, valid, err);
    end
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    nv = 0;
    ne = 0;
    ybad = 0;
    for (int i = 0; i < FL + 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      nv += int'(valid);
      ne += int'(err);
      if (Y0 !== '0 || Y1 !== '0) ybad++;
    end
    checks++;
    if (nv !== 0 || ne !== 0 || ybad !== 0) begin
      errors++;
      $display("FAIL midreset_quiet vcnt=%0d ecnt=%0d ybad=%0d need 0/0/0", nv, ne, ybad);
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int nv, ne;
    send_bits(8'hA5, 8'h3C, 1'b0, 0, FL, nv, ne);
    checks++;
    if (valid !== 1'b1 || err !== 1'b0 || Y0 !== 8'hA5 || Y1 !== 8'h3C || nv !== 0) begin
      errors++;
      $display("FAIL parity_good valid=%b err=%b Y0=%h Y1=%h need 1/0/a5/3c", valid, err, Y0, Y1);
    end
    send_bits(8'hA5, 8'h3C, 1'b1, 0, FL, nv, ne);
    checks++;
    if (valid !== 1'b0 || err !== 1'b1 || Y0 !== 8'hA5 || Y1 !== 8'h3C || nv !== 0 || ne !== 0) begin
      errors++;
      $display("FAIL parity_bad valid=%b err=%b Y0=%h Y1=%h need 0/1/a5/3c", valid, err, Y0, Y1);
    end
    send_bits(8'h12, 8'h34, 1'b1, 0, FL, nv, ne);
    checks++;
    if (valid !== 1'b0 || err !== 1'b1 || Y0 !== 8'hA5 || Y1 !== 8'h3C) begin
      errors++;
      $display("FAIL parity_bad_hold valid=%b err=%b Y0=%h Y1=%h need 0/1/a5/3c", valid, err, Y0, Y1);
    end
  endtask
`else
  task automatic test_extra_bit();
    int nv, ne;
    send_bits(8'h5A, 8'hC3, 1'b0, 0, FL, nv, ne);
    checks++;
    if (valid !== 1'b1 || Y0 !== 8'h5A || Y1 !== 8'hC3) begin
      errors++;
      $display("FAIL extra_frame valid=%b Y0=%h Y1=%h need 1/5a/c3", valid, Y0, Y1);
    end
    nv = 0;
    ne = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      nv += int'(valid);
      ne += int'(err);
    end
    checks++;
    if (nv !== 0 || ne !== 0 || Y0 !== 8'h5A || Y1 !== 8'hC3) begin
      errors++;
      $display("FAIL extra_bit vcnt=%0d ecnt=%0d Y0=%h Y1=%h need 0/0/5a/c3", nv, ne, Y0, Y1);
    end
  endtask
`endif

  task automatic push_cycle(input logic d, input logic s, input logic v, input logic e);
    q_d.push_back(d);
    q_s.push_back(s);
    q_v.push_back(v);
    q_e.push_back(e);
    q_y0.push_back(m_y0);
    q_y1.push_back(m_y1);
  endtask

  // A frame of len < FL is cut short by the next frame's sync.
  task automatic push_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int len, input logic bad);
    logic v, e;
    for (int k = 0; k < len; k++) begin
      v = 1'b0;
      e = (k == 0) ? m_pend : 1'b0;
      if (len == FL && k == FL - 1) begin
        if (bad) e = 1'b1;
        else begin
          v    = 1'b1;
          m_y0 = a;
          m_y1 = b;
        end
      end
      push_cycle(fbit(a, b, k) ^ (bad && k == DL), k == 0, v, e);
    end
    m_pend = (len != FL);
  endtask

  task automatic test_random();
    int sel;
    logic bad;
    rst_n = 1'b0;
    #2;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    m_y0   = '0;
    m_y1   = '0;
    m_pend = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      sel = int'($urandom_range(0, 3));
`ifdef PARITY_EN
      bad = ($urandom_range(0, 3) == 0);
`else
      bad = 1'b0;
`endif
      if (sel == 0 && !m_pend) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++)
          push_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      end else if (sel == 1) begin
        push_frame(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(1, FL - 1)), 1'b0);
      end else begin
        push_frame(WIDTH'($urandom), WIDTH'($urandom), FL, bad);
      end
    end
    if (m_pend) push_frame(WIDTH'($urandom), WIDTH'($urandom), FL, 1'b0);
    push_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < q_d.size(); i++) begin
      step(q_d[i], q_s[i]);
      checks++;
      if (valid !== q_v[i] || err !== q_e[i] || Y0 !== q_y0[i] || Y1 !== q_y1[i]) begin
        errors++;
        $display("FAIL random cyc=%0d valid=%b err=%b Y0=%h Y1=%h need %b/%b/%h/%h",
                 i, valid, err, Y0, Y1, q_v[i], q_e[i], q_y0[i], q_y1[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
`ifdef PARITY_EN
    test_parity();
`else
    test_extra_bit();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
